// File: rtl/ulpi_reg_access.sv
// ULPI register read/write engine with DIR-abort retry and bus-wait timeout.
// Define ULPI_REG_EXT_ADDR_EN to enable the extended-address (8-bit) sequence.
module ulpi_reg_access #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       REQ,
    input  logic       RW,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    input  logic       DIR,
    input  logic       NXT,
    output logic       STP,
    output logic [7:0] ULPI_DATA_OUT,
    input  logic [7:0] ULPI_DATA_IN,
    output logic       ULPI_OE
);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TXCMD,
`ifdef ULPI_REG_EXT_ADDR_EN
        S_EXT_ADDR,
`endif
        S_WR_DATA,
        S_WR_STP,
        S_RD_TURN,
        S_RD_DATA,
        S_RD_END,
        S_ABORT
    } state_t;

    state_t          r_state, w_state;
    logic            r_oe, w_oe;
    logic [7:0]      r_data, w_data;
    logic            r_stp, w_stp;
    logic            r_done, w_done;
    logic            r_err, w_err;
    logic            r_busy;
    logic [7:0]      r_rdata, w_rdata;
    logic [RW_W-1:0] r_retry, w_retry;
    logic [TW-1:0]   r_tmo, w_tmo;
    logic            r_rw, w_rw;
    logic [7:0]      r_wdata, w_wdata;
    logic [7:0]      r_txcmd, w_txcmd;
    logic            w_ext_req;
    logic [5:0]      w_a6;
    logic            w_cnt;
    logic            w_cont;
`ifdef ULPI_REG_EXT_ADDR_EN
    logic            r_ext, w_ext;
    logic [7:0]      r_addr, w_addr;
`endif

    assign w_ext_req = (ADDR > 8'h3F) || (ADDR == 8'h2F);
    assign w_a6      = w_ext_req ? 6'h2F : ADDR[5:0];

    always_comb begin
        w_state = r_state;
        w_oe    = r_oe;
        w_data  = r_data;
        w_stp   = r_stp;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_rdata = r_rdata;
        w_retry = r_retry;
        w_tmo   = '0;
        w_rw    = r_rw;
        w_wdata = r_wdata;
        w_txcmd = r_txcmd;
        w_cnt   = 1'b0;
        w_cont  = 1'b0;
`ifdef ULPI_REG_EXT_ADDR_EN
        w_ext   = r_ext;
        w_addr  = r_addr;
`endif
        unique case (r_state)
            S_IDLE: begin
                // Skip the ERR cycle so a still-held REQ is not rejected twice
                if (REQ && !DIR && !r_err) begin
`ifndef ULPI_REG_EXT_ADDR_EN
                    if (w_ext_req) begin
                        w_err = 1'b1;
                    end else
`endif
                    begin
                        w_rw    = RW;
                        w_wdata = WDATA;
                        w_txcmd = {1'b1, RW, w_a6};
                        w_data  = {1'b1, RW, w_a6};
                        w_oe    = 1'b1;
                        w_retry = '0;
                        w_state = S_TXCMD;
`ifdef ULPI_REG_EXT_ADDR_EN
                        w_ext   = w_ext_req;
                        w_addr  = ADDR;
`endif
                    end
                end
            end
            S_TXCMD: begin
                w_cnt = 1'b1;
                if (DIR) begin
                    w_state = S_ABORT;
                    w_oe    = 1'b0;
                    w_data  = 8'h00;
                end else if (NXT) begin
`ifdef ULPI_REG_EXT_ADDR_EN
                    if (r_ext) begin
                        w_data  = r_addr;
                        w_state = S_EXT_ADDR;
                    end else
`endif
                    w_cont = 1'b1;
                end
            end
`ifdef ULPI_REG_EXT_ADDR_EN
            S_EXT_ADDR: begin
                w_cnt = 1'b1;
                if (DIR) begin
                    w_state = S_ABORT;
                    w_oe    = 1'b0;
                    w_data  = 8'h00;
                end else if (NXT) begin
                    w_cont = 1'b1;
                end
            end
`endif
            S_WR_DATA: begin
                w_cnt = 1'b1;
                if (DIR) begin
                    w_state = S_ABORT;
                    w_oe    = 1'b0;
                    w_data  = 8'h00;
                end else if (NXT) begin
                    w_stp   = 1'b1;
                    w_data  = 8'h00;
                    w_state = S_WR_STP;
                end
            end
            S_WR_STP: begin
                w_stp   = 1'b0;
                w_oe    = 1'b0;
                w_data  = 8'h00;
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            S_RD_TURN: begin
                w_cnt = 1'b1;
                if (DIR) w_state = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (!DIR) begin
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else if (NXT) begin
                    w_state = S_ABORT;
                end else begin
                    w_rdata = ULPI_DATA_IN;
                    w_state = S_RD_END;
                end
            end
            S_RD_END: begin
                w_cnt = 1'b1;
                if (!DIR) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end
            end
            S_ABORT: begin
                w_cnt = 1'b1;
                if (!DIR) begin
                    if (r_retry < RW_W'(MAX_RETRY)) begin
                        w_retry = r_retry + RW_W'(1);
                        w_data  = r_txcmd;
                        w_oe    = 1'b1;
                        w_state = S_TXCMD;
                    end else begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Address phase accepted: read turns the bus around, write sends data
        if (w_cont) begin
            if (r_rw) begin
                w_oe    = 1'b0;
                w_data  = 8'h00;
                w_state = S_RD_TURN;
            end else begin
                w_data  = r_wdata;
                w_state = S_WR_DATA;
            end
        end

        if (w_cnt && (w_state == r_state)) begin
            if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                w_err   = 1'b1;
                w_oe    = 1'b0;
                w_stp   = 1'b0;
                w_data  = 8'h00;
                w_state = S_IDLE;
            end else begin
                w_tmo = r_tmo + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_data  <= 8'h00;
            r_stp   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 8'h00;
            r_retry <= '0;
            r_tmo   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= 8'h00;
            r_txcmd <= 8'h00;
`ifdef ULPI_REG_EXT_ADDR_EN
            r_ext   <= 1'b0;
            r_addr  <= 8'h00;
`endif
        end else begin
            r_state <= w_state;
            r_oe    <= w_oe;
            r_data  <= w_data;
            r_stp   <= w_stp;
            r_done  <= w_done;
            r_err   <= w_err;
            r_busy  <= (w_state != S_IDLE);
            r_rdata <= w_rdata;
            r_retry <= w_retry;
            r_tmo   <= w_tmo;
            r_rw    <= w_rw;
            r_wdata <= w_wdata;
            r_txcmd <= w_txcmd;
`ifdef ULPI_REG_EXT_ADDR_EN
            r_ext   <= w_ext;
            r_addr  <= w_addr;
`endif
        end
    end

    assign ULPI_DATA_OUT = r_data;
    assign ULPI_OE       = r_oe;
    assign STP           = r_stp;
    assign DONE          = r_done;
    assign ERR           = r_err;
    assign BUSY          = r_busy;
    assign RDATA         = r_rdata;
endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed self-checking bench for ulpi_reg_access.
module tb_ulpi_reg_access;
    localparam int TMO = 255;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       REQ, RW, DIR, NXT;
    logic [7:0] ADDR, WDATA, ULPI_DATA_IN;
    logic [7:0] RDATA, ULPI_DATA_OUT;
    logic       BUSY, DONE, ERR, STP, ULPI_OE;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stp_cnt = 0;

    ulpi_reg_access #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .REQ(REQ), .RW(RW), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .DIR(DIR), .NXT(NXT), .STP(STP),
        .ULPI_DATA_OUT(ULPI_DATA_OUT), .ULPI_DATA_IN(ULPI_DATA_IN),
        .ULPI_OE(ULPI_OE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DONE) done_cnt++;
        if (ERR) err_cnt++;
        if (STP) stp_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rw, input logic [7:0] a, input logic [7:0] d);
        REQ = 1'b1; RW = rw; ADDR = a; WDATA = d;
        tick();
        REQ = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({ULPI_OE, STP, BUSY, DONE, ERR} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000", {ULPI_OE, STP, BUSY, DONE, ERR});
        end
        checks++;
        if (ULPI_DATA_OUT !== 8'h00 || RDATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 00/00", ULPI_DATA_OUT, RDATA);
        end
    endtask

    task automatic test_write();
        start(1'b0, 8'h04, 8'h45);
        checks++;
        if (ULPI_OE !== 1'b1 || ULPI_DATA_OUT !== 8'h84 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL wr_txcmd: got oe=%b d=%h busy=%b want 1 84 1", ULPI_OE, ULPI_DATA_OUT, BUSY);
        end
        NXT = 1'b1;
        tick();
        checks++;
        if (ULPI_OE !== 1'b1 || ULPI_DATA_OUT !== 8'h45) begin
            errors++;
            $display("FAIL wr_data: got oe=%b d=%h want 1 45", ULPI_OE, ULPI_DATA_OUT);
        end
        tick();
        NXT = 1'b0;
        checks++;
        if (STP !== 1'b1 || ULPI_DATA_OUT !== 8'h00 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL wr_stp: got stp=%b d=%h done=%b want 1 00 0", STP, ULPI_DATA_OUT, DONE);
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || ULPI_OE !== 1'b0 || STP !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: got done=%b busy=%b oe=%b stp=%b want 1 0 0 0", DONE, BUSY, ULPI_OE, STP);
        end
        tick();
        checks++;
        if (DONE !== 1'b0 || ULPI_OE !== 1'b0) begin
            errors++;
            $display("FAIL wr_after: got done=%b oe=%b want 0 0", DONE, ULPI_OE);
        end
    endtask

    task automatic test_read();
        int d0;
        d0 = done_cnt;
        start(1'b1, 8'h0A, 8'h00);
        checks++;
        if (ULPI_OE !== 1'b1 || ULPI_DATA_OUT !== 8'hCA) begin
            errors++;
            $display("FAIL rd_txcmd: got oe=%b d=%h want 1 CA", ULPI_OE, ULPI_DATA_OUT);
        end
        NXT = 1'b1;
        tick();
        NXT = 1'b0;
        DIR = 1'b1;
        checks++;
        if (ULPI_OE !== 1'b0 || ULPI_DATA_OUT !== 8'h00) begin
            errors++;
            $display("FAIL rd_turn_oe: got oe=%b d=%h want 0 00", ULPI_OE, ULPI_DATA_OUT);
        end
        tick();
        ULPI_DATA_IN = 8'h5A;
        tick();
        ULPI_DATA_IN = 8'hFF;
        DIR = 1'b0;
        tick();
        checks++;
        if (DONE !== 1'b1 || RDATA !== 8'h5A || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: got done=%b rdata=%h busy=%b want 1 5A 0", DONE, RDATA, BUSY);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt - d0 !== 1 || RDATA !== 8'h5A) begin
            errors++;
            $display("FAIL rd_once: got pulses=%0d rdata=%h want 1 5A", done_cnt - d0, RDATA);
        end
    endtask

    task automatic test_abort_retry();
        int e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start(1'b0, 8'h04, 8'h45);
        for (int i = 0; i < 2; i++) begin
            DIR = 1'b1;
            tick();
            checks++;
            if (ULPI_OE !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL ab_abort%0d: got oe=%b busy=%b want 0 1", i, ULPI_OE, BUSY);
            end
            DIR = 1'b0;
            tick();
            checks++;
            if (ULPI_OE !== 1'b1 || ULPI_DATA_OUT !== 8'h84) begin
                errors++;
                $display("FAIL ab_redrive%0d: got oe=%b d=%h want 1 84", i, ULPI_OE, ULPI_DATA_OUT);
            end
        end
        NXT = 1'b1;
        tick();
        tick();
        NXT = 1'b0;
        tick();
        tick();
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL ab_final: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_retry_exhaust();
        int e0;
        e0 = err_cnt;
        start(1'b0, 8'h04, 8'h45);
        for (int i = 0; i <= MR; i++) begin
            DIR = 1'b1;
            tick();
            DIR = 1'b0;
            tick();
        end
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0 || ULPI_OE !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL rx_err: got err=%b busy=%b oe=%b done=%b want 1 0 0 0", ERR, BUSY, ULPI_OE, DONE);
        end
        repeat (3) tick();
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL rx_once: got %0d pulses want 1", err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int s0, n;
        s0 = stp_cnt;
        n = 1;
        start(1'b0, 8'h04, 8'h45);
        while (ERR !== 1'b1 && n < TMO + 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TMO + 1) begin
            errors++;
            $display("FAIL tmo_cycle: got ERR at cycle %0d want %0d", n, TMO + 1);
        end
        checks++;
        if (stp_cnt - s0 !== 0 || ULPI_OE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL tmo_bus: got stp=%0d oe=%b busy=%b want 0 0 0", stp_cnt - s0, ULPI_OE, BUSY);
        end
        tick();
    endtask

    task automatic test_ext_addr();
`ifdef ULPI_REG_EXT_ADDR_EN
        start(1'b0, 8'h80, 8'h33);
        checks++;
        if (ULPI_OE !== 1'b1 || ULPI_DATA_OUT !== 8'hAF) begin
            errors++;
            $display("FAIL ext_txcmd: got oe=%b d=%h want 1 AF", ULPI_OE, ULPI_DATA_OUT);
        end
        NXT = 1'b1;
        tick();
        checks++;
        if (ULPI_DATA_OUT !== 8'h80) begin
            errors++;
            $display("FAIL ext_addr: got %h want 80", ULPI_DATA_OUT);
        end
        tick();
        checks++;
        if (ULPI_DATA_OUT !== 8'h33) begin
            errors++;
            $display("FAIL ext_data: got %h want 33", ULPI_DATA_OUT);
        end
        tick();
        NXT = 1'b0;
        checks++;
        if (STP !== 1'b1) begin
            errors++;
            $display("FAIL ext_stp: got %b want 1", STP);
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || ULPI_OE !== 1'b0) begin
            errors++;
            $display("FAIL ext_done: got done=%b oe=%b want 1 0", DONE, ULPI_OE);
        end
        tick();
`else
        int e0;
        e0 = err_cnt;
        REQ = 1'b1; RW = 1'b0; ADDR = 8'h80; WDATA = 8'h33;
        tick();
        checks++;
        if (ERR !== 1'b1 || ULPI_OE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ext_rej: got err=%b oe=%b busy=%b want 1 0 0", ERR, ULPI_OE, BUSY);
        end
        REQ = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (ULPI_OE !== 1'b0 || ULPI_DATA_OUT !== 8'h00) begin
                errors++;
                $display("FAIL ext_idle: got oe=%b d=%h want 0 00", ULPI_OE, ULPI_DATA_OUT);
            end
        end
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL ext_once: got %0d pulses want 1", err_cnt - e0);
        end
`endif
    endtask

    task automatic test_async_reset();
        start(1'b0, 8'h04, 8'h45);
        NXT = 1'b1;
        tick();
        checks++;
        if (ULPI_DATA_OUT !== 8'h45 || ULPI_OE !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got oe=%b d=%h want 1 45", ULPI_OE, ULPI_DATA_OUT);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ULPI_OE !== 1'b0 || STP !== 1'b0 || BUSY !== 1'b0 || ULPI_DATA_OUT !== 8'h00) begin
            errors++;
            $display("FAIL ar_drop: got oe=%b stp=%b busy=%b d=%h want 0 0 0 00", ULPI_OE, STP, BUSY, ULPI_DATA_OUT);
        end
        NXT = 1'b0;
        #1 rst = 1'b0;
        tick();
        checks++;
        if (STP !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ar_after: got stp=%b busy=%b want 0 0", STP, BUSY);
        end
    endtask

    initial begin
        rst = 1'b1;
        REQ = 1'b0; RW = 1'b0; ADDR = 8'h00; WDATA = 8'h00;
        DIR = 1'b0; NXT = 1'b0; ULPI_DATA_IN = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_write();
        test_read();
        test_abort_retry();
        test_retry_exhaust();
        test_timeout();
        test_ext_addr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ulpi_reg_access.md
Name: ulpi_reg_access

Overview:
Parametrised ULPI register access engine: performs register writes and register reads on the USB3300 PHY over the ULPI bus, with DIR-abort retry and NXT/DIR timeout. Sits between the sniffer's ULPI controller and the ULPI pins. The controller issues one request at a time and gets a DONE or ERR pulse back. Bus sharing with the RX path is done by the pin-level mux using ULPI_OE.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent waiting in any bus-wait state before ERR; counter width $clog2(TIMEOUT_CYCLES+1)
MAX_RETRY, 3, number of restarts after a DIR abort before ERR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
REQ  in  1  access request; level, held by requester until BUSY=1
RW  in  1  1=read, 0=write; sampled with REQ
ADDR  in  8  register address; sampled with REQ
WDATA  in  8  write data; sampled with REQ
RDATA  out  8  read result; valid from DONE pulse until next accepted read
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse: access completed
ERR  out  1  one-cycle pulse: access failed (timeout, retries exhausted, bad address)
DIR  in  1  ULPI DIR
NXT  in  1  ULPI NXT
STP  out  1  ULPI STP
ULPI_DATA_OUT  out  8  link-driven bus value
ULPI_DATA_IN  in  8  PHY-driven bus value
ULPI_OE  out  1  1 = link drives ULPI data bus

Behaviour:
- Reset (async): state IDLE; STP, ULPI_OE, BUSY, DONE, ERR = 0; ULPI_DATA_OUT = 0x00; RDATA = 0x00; retry and timeout counters = 0. Reset mid-access drops the bus immediately, with no STP.
- All outputs registered. ULPI_DATA_OUT = 0x00 whenever ULPI_OE=0.
- TXCMD = {RW ? 2'b11 : 2'b10, A6}. A6 = ADDR[5:0] for immediate addresses, 6'h2F for extended addresses.
- Timeout counter clears on every state entry and counts in TXCMD, EXT_ADDR, WR_DATA, RD_TURN, RD_END and ABORT. On reaching TIMEOUT_CYCLES: ERR pulse, ULPI_OE=0, STP=0, go to IDLE.
- States and transitions:
  - IDLE: accept when REQ=1 and DIR=0. Latch RW/ADDR/WDATA, load TXCMD, ULPI_OE<=1, retry counter <= 0, go to TXCMD. REQ=1 with DIR=1 waits in IDLE.
  - TXCMD: DIR=1 (takes priority over NXT) -> ABORT. Else NXT=1:
    - extended address: drive ADDR, go to EXT_ADDR
    - write: drive WDATA, go to WR_DATA
    - read: ULPI_OE<=0, go to RD_TURN
  - EXT_ADDR: DIR=1 -> ABORT. NXT=1 -> same continuation as TXCMD for write or read.
  - WR_DATA: DIR=1 -> ABORT. NXT=1 -> STP<=1, data 0x00, go to WR_STP.
  - WR_STP: STP<=0, ULPI_OE<=0, DONE pulse, go to IDLE.
  - RD_TURN: DIR=1 -> RD_DATA (turnaround cycle, data ignored).
  - RD_DATA:
    - DIR=1, NXT=0: RDATA <= ULPI_DATA_IN, go to RD_END
    - DIR=1, NXT=1 (PHY RX interrupts the read): go to ABORT
    - DIR=0: ERR pulse, go to IDLE
  - RD_END: DIR=0 -> DONE pulse, go to IDLE.
  - ABORT: ULPI_OE=0, wait for DIR=0.
    - If retry < MAX_RETRY: retry++, reload TXCMD, ULPI_OE<=1, go to TXCMD.
    - Else: ERR pulse, go to IDLE.
- Latency, immediate write with NXT answered on the first cycle: REQ accepted at cycle 0; TXCMD on the bus at 1; WDATA at 2; STP at 3; DONE at 4.
- DONE and ERR never assert in the same cycle. BUSY drops in the cycle DONE or ERR pulses.

Optional Feature:
ULPI_REG_EXT_ADDR_EN.
- Defined: ADDR > 0x3F or ADDR == 0x2F uses the extended sequence (TXCMD with A6=6'h2F, then the ADDR byte in EXT_ADDR).
- Undefined: EXT_ADDR state is absent. Such addresses are rejected at acceptance: ERR pulse the cycle after REQ, no bus activity (ULPI_OE stays 0).

Test Plan:
- Write ADDR=0x04, WDATA=0x45, NXT high on the 1st and 2nd driven cycles -> bus 0x84 then 0x45, STP one cycle with data 0x00, DONE at cycle 4, ULPI_OE 0 afterwards.
- Read ADDR=0x0A, PHY: NXT, DIR turnaround, data 0x5A, DIR low -> bus 0xCA, ULPI_OE drops after NXT, RDATA=0x5A, DONE once.
- Write with DIR asserted during TXCMD twice, then clean -> two ABORTs, TXCMD 0x84 re-driven each time, final DONE, no ERR.
- DIR abort MAX_RETRY+1 times -> exactly one ERR pulse, BUSY=0, ULPI_OE=0.
- NXT never asserted -> ERR after TIMEOUT_CYCLES in TXCMD, no STP.
- ADDR=0x80 write:
  - macro defined: bus 0xAF, 0x80, WDATA, STP, DONE
  - macro undefined: ERR the next cycle, no bus activity
- Async rst pulse while in WR_DATA -> ULPI_OE, STP, BUSY = 0 immediately.
